hv_timing_gen: RTL and testbench



---
 rtl/hv_timing_gen_pkg.sv | 21 ++
 rtl/hv_timing_gen_if.sv | 33 +++
 rtl/hv_timing_gen_ce_delay.sv | 31 +++
 rtl/hv_timing_gen.sv | 151 +++++++++++++++
 tb/tb_hv_timing_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hv_timing_gen_pkg.sv
// Shared definitions for the H/V timing generator: default ATetris geometry and sync offset clamp.
package hv_timing_pkg;

    localparam int ATETRIS_CW       = 9;
    localparam int ATETRIS_H_TOTAL  = 456;
    localparam int ATETRIS_H_ACTIVE = 336;
    localparam int ATETRIS_V_TOTAL  = 262;
    localparam int ATETRIS_V_ACTIVE = 240;

    // Sync start = nominal + step*offs, kept inside [lo, hi] so sync never enters the active area
    // and never runs past the end of the line/frame.
    function automatic int offs_clamp(input int nominal, input int step, input int offs,
                                      input int lo, input int hi);
        int v;
        v = nominal + step * offs;
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/hv_timing_gen_if.sv
// Video bus between the timing generator and the game core / video output stage.
interface hv_timing_if
    import hv_timing_pkg::*;
#(
    parameter int CW       = ATETRIS_CW,
    parameter int H_OFFS_W = 5,
    parameter int V_OFFS_W = 3,
    parameter int RGB_W    = 8
);
    logic signed [H_OFFS_W-1:0] HOFFS;
    logic signed [V_OFFS_W-1:0] VOFFS;
    logic        [RGB_W-1:0]    iRGB;
    logic        [CW-1:0]       HPOS;
    logic        [CW-1:0]       VPOS;
    logic        [RGB_W-1:0]    oRGB;
    logic                       HBLK;
    logic                       VBLK;
    logic                       HSYN;
    logic                       VSYN;
    logic                       CSYN;
    logic                       SOF;
    logic                       FIELD;

    modport master (
        input  HOFFS, VOFFS, iRGB,
        output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, CSYN, SOF, FIELD
    );

    modport slave (
        output HOFFS, VOFFS, iRGB,
        input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, CSYN, SOF, FIELD
    );
endinterface

// File: rtl/hv_timing_gen_ce_delay.sv
// Clock-enable gated shift register; DEPTH=0 is a straight wire. Reset loads FILL into every stage.
module hv_ce_delay #(
    parameter int            W     = 1,
    parameter int            DEPTH = 1,
    parameter logic [W-1:0]  FILL  = '1
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_sr
        logic [W-1:0] sr [DEPTH];

        always_ff @(posedge clk_sys or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= FILL;
            end else if (ce) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/hv_timing_gen.sv
// Parametrised H/V timing generator with frame-latched, clamped sync offsets and pipeline-aligned blank/sync/RGB.
// Optional composite sync: define HV_TIMING_CSYNC_EN, otherwise CSYN is tied high.
module hv_timing_gen
    import hv_timing_pkg::*;
#(
    parameter int CW           = ATETRIS_CW,
    parameter int H_TOTAL      = ATETRIS_H_TOTAL,
    parameter int H_ACTIVE     = ATETRIS_H_ACTIVE,
    parameter int H_SYNC_START = 360,
    parameter int H_SYNC_WIDTH = 24,
    parameter int V_TOTAL      = ATETRIS_V_TOTAL,
    parameter int V_ACTIVE     = ATETRIS_V_ACTIVE,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 3,
    parameter int H_OFFS_W     = 5,
    parameter int V_OFFS_W     = 3,
    parameter int OFFS_STEP    = 2,
    parameter int PIX_LAT      = 1,
    parameter int RGB_W        = 8
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ce_pix,
    hv_timing_if.master vid
);

    localparam int SW = CW + 2;

    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_err_hsync
        $error("hv_timing_gen: hsync runs past H_TOTAL");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_err_cw
        $error("hv_timing_gen: counters too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIX_LAT < 0) begin : g_err_lat
        $error("hv_timing_gen: PIX_LAT must be non-negative");
    end

    logic [CW-1:0]              hcnt, vcnt;
    logic signed [H_OFFS_W-1:0] hoffs_sh;
    logic signed [V_OFFS_W-1:0] voffs_sh;
    logic                       sof_q, field_q;
    logic [SW-1:0]              hs_start, vs_start, hpos_w, vpos_w;
    logic                       hb_raw, vb_raw, hs_n_raw, vs_n_raw;
    logic [3:0]                 dly_q;
    logic                       d_hb, d_vb, d_hs_n, d_vs_n;
    logic                       hblk_q, vblk_q, hsyn_q, vsyn_q;
    logic [RGB_W-1:0]           orgb_q;

    // Offsets are only sampled on the last pixel of the frame so a frame never mixes two sync positions.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            hcnt     <= '0;
            vcnt     <= '0;
            hoffs_sh <= '0;
            voffs_sh <= '0;
            sof_q    <= 1'b0;
            field_q  <= 1'b0;
        end else begin
            sof_q <= 1'b0;
            if (ce_pix) begin
                if (hcnt == CW'(H_TOTAL - 1)) begin
                    hcnt <= '0;
                    if (vcnt == CW'(V_TOTAL - 1)) begin
                        vcnt     <= '0;
                        hoffs_sh <= vid.HOFFS;
                        voffs_sh <= vid.VOFFS;
                        sof_q    <= 1'b1;
                        field_q  <= ~field_q;
                    end else begin
                        vcnt <= vcnt + CW'(1);
                    end
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        hs_start = SW'(offs_clamp(H_SYNC_START, OFFS_STEP, int'(hoffs_sh),
                                  H_ACTIVE, H_TOTAL - H_SYNC_WIDTH));
        vs_start = SW'(offs_clamp(V_SYNC_START, OFFS_STEP, int'(voffs_sh),
                                  V_ACTIVE, V_TOTAL - V_SYNC_WIDTH));
        hpos_w   = {2'b00, hcnt};
        vpos_w   = {2'b00, vcnt};
        hb_raw   = hcnt >= CW'(H_ACTIVE);
        vb_raw   = vcnt >= CW'(V_ACTIVE);
        hs_n_raw = !((hpos_w >= hs_start) && (hpos_w < hs_start + SW'(H_SYNC_WIDTH)));
        vs_n_raw = !((vpos_w >= vs_start) && (vpos_w < vs_start + SW'(V_SYNC_WIDTH)));
    end

    hv_ce_delay #(
        .W     (4),
        .DEPTH (PIX_LAT),
        .FILL  (4'hF)
    ) u_dly (
        .clk_sys (clk_sys),
        .rst     (RESET),
        .ce      (ce_pix),
        .d       ({hb_raw, vb_raw, hs_n_raw, vs_n_raw}),
        .q       (dly_q)
    );

    assign {d_hb, d_vb, d_hs_n, d_vs_n} = dly_q;

    // iRGB lags HPOS by PIX_LAT, so gating it with the delayed blank keeps pixel and blank aligned.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            hblk_q <= 1'b1;
            vblk_q <= 1'b1;
            hsyn_q <= 1'b1;
            vsyn_q <= 1'b1;
            orgb_q <= '0;
        end else if (ce_pix) begin
            hblk_q <= d_hb;
            vblk_q <= d_vb;
            hsyn_q <= d_hs_n;
            vsyn_q <= d_vs_n;
            orgb_q <= (d_hb || d_vb) ? '0 : vid.iRGB;
        end
    end

`ifdef HV_TIMING_CSYNC_EN
    logic csyn_q;

    // XOR of active-high syncs serrates hsync pulses during vsync.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            csyn_q <= 1'b1;
        end else if (ce_pix) begin
            csyn_q <= ~((~d_hs_n) ^ (~d_vs_n));
        end
    end

    assign vid.CSYN = csyn_q;
`else
    assign vid.CSYN = 1'b1;
`endif

    assign vid.HPOS  = hcnt;
    assign vid.VPOS  = vcnt;
    assign vid.oRGB  = orgb_q;
    assign vid.HBLK  = hblk_q;
    assign vid.VBLK  = vblk_q;
    assign vid.HSYN  = hsyn_q;
    assign vid.VSYN  = vsyn_q;
    assign vid.SOF   = sof_q;
    assign vid.FIELD = field_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Directed bench for hv_timing_gen on a reduced 40x20 geometry so several full frames fit in a short run.
module tb_hv_timing_gen;

    localparam int HT  = 40;
    localparam int HA  = 24;
    localparam int HSS = 28;
    localparam int HSW = 4;
    localparam int VT  = 20;
    localparam int VA  = 12;
    localparam int VSS = 14;
    localparam int VSW = 2;
    localparam int FR  = HT * VT;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;
    logic ce_pix  = 1'b0;

    hv_timing_if #(.CW(9), .H_OFFS_W(5), .V_OFFS_W(3), .RGB_W(8)) vid ();

    hv_timing_gen #(
        .CW(9), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .H_OFFS_W(5), .V_OFFS_W(3), .OFFS_STEP(2), .PIX_LAT(1), .RGB_W(8)
    ) dut (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .ce_pix  (ce_pix),
        .vid     (vid)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;
    int mpos;
    logic prev_hsyn, prev_vsyn, exp_field;
    int fr_hs_first, fr_hs_last, fr_vs_line, fr_vs_col;
    int fr_hsyn_low, fr_vsyn_low, fr_sof, fr_aa, fr_err, fr_csyn_err;
    int hold_err;

    // Frame table: offsets written at set_line take effect in the following frame.
    int              t_set [6] = '{-1, 5, 5, 5, 5, -1};
    logic signed [4:0] t_nh [6] = '{5'sd0, 5'sd3, -5'sd16, 5'sd15, 5'sd0, 5'sd0};
    logic signed [2:0] t_nv [6] = '{3'sd0, 3'sd0, 3'sd0, 3'sd3, -3'sd4, 3'sd0};
    bit              t_aa  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int              t_hs  [6] = '{30, 30, 36, 26, 38, 30};
    int              t_vs  [6] = '{14, 14, 14, 14, 18, 12};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int q);
        return 8'((q % HT) * 3 + (q / HT) * 17 + 1);
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_frame(input int set_line, input logic signed [4:0] nh,
                             input logic signed [2:0] nv, input bit aa_mode);
        int q;
        logic e_hb, e_vb;
        logic [7:0] e_rgb;
        fr_hs_first = -1; fr_hs_last = -1; fr_vs_line = -1; fr_vs_col = -1;
        fr_hsyn_low = 0; fr_vsyn_low = 0; fr_sof = 0; fr_aa = 0; fr_err = 0; fr_csyn_err = 0;
        for (int t = 0; t < FR; t++) begin
            if (set_line >= 0 && mpos == set_line * HT) begin
                vid.HOFFS = nh;
                vid.VOFFS = nv;
            end
            vid.iRGB = aa_mode ? 8'hAA : pix_of((mpos + FR - 1) % FR);
            tick();
            mpos  = (mpos + 1) % FR;
            q     = (mpos + FR - 2) % FR;
            e_hb  = (q % HT) >= HA;
            e_vb  = (q / HT) >= VA;
            e_rgb = (e_hb || e_vb) ? 8'h00 : (aa_mode ? 8'hAA : pix_of(q));
            if (vid.HPOS !== 9'(mpos % HT) || vid.VPOS !== 9'(mpos / HT) ||
                vid.HBLK !== e_hb || vid.VBLK !== e_vb || vid.oRGB !== e_rgb)
                fr_err++;
            if (prev_hsyn === 1'b1 && vid.HSYN === 1'b0) begin
                if (fr_hs_first < 0) fr_hs_first = int'(vid.HPOS);
                fr_hs_last = int'(vid.HPOS);
            end
            if (prev_vsyn === 1'b1 && vid.VSYN === 1'b0 && fr_vs_line < 0) begin
                fr_vs_line = int'(vid.VPOS);
                fr_vs_col  = int'(vid.HPOS);
            end
            prev_hsyn = vid.HSYN;
            prev_vsyn = vid.VSYN;
            if (vid.HSYN === 1'b0) fr_hsyn_low++;
            if (vid.VSYN === 1'b0) fr_vsyn_low++;
            if (vid.SOF === 1'b1) fr_sof++;
            if (vid.oRGB === 8'hAA) fr_aa++;
`ifdef HV_TIMING_CSYNC_EN
            if (vid.CSYN !== ~((~vid.HSYN) ^ (~vid.VSYN))) fr_csyn_err++;
`else
            if (vid.CSYN !== 1'b1) fr_csyn_err++;
`endif
        end
    endtask

    initial begin
        vid.HOFFS = '0;
        vid.VOFFS = '0;
        vid.iRGB  = 8'h00;
        repeat (2) tick();

        chk("rst_hpos",  vid.HPOS,  0);
        chk("rst_vpos",  vid.VPOS,  0);
        chk("rst_hblk",  vid.HBLK,  1);
        chk("rst_vblk",  vid.VBLK,  1);
        chk("rst_hsyn",  vid.HSYN,  1);
        chk("rst_vsyn",  vid.VSYN,  1);
        chk("rst_csyn",  vid.CSYN,  1);
        chk("rst_orgb",  vid.oRGB,  0);
        chk("rst_sof",   vid.SOF,   0);
        chk("rst_field", vid.FIELD, 0);

        @(negedge clk_sys);
        RESET     = 1'b0;
        ce_pix    = 1'b1;
        mpos      = 0;
        prev_hsyn = 1'b1;
        prev_vsyn = 1'b1;
        exp_field = 1'b0;

        for (int f = 0; f < 6; f++) begin
            run_frame(t_set[f], t_nh[f], t_nv[f], t_aa[f]);
            exp_field = ~exp_field;
            chk($sformatf("f%0d_hs_first", f), fr_hs_first, t_hs[f]);
            chk($sformatf("f%0d_hs_last", f),  fr_hs_last,  t_hs[f]);
            chk($sformatf("f%0d_vs_line", f),  fr_vs_line,  t_vs[f]);
            chk($sformatf("f%0d_sof", f),      fr_sof,      1);
            chk($sformatf("f%0d_pix_err", f),  fr_err,      0);
            chk($sformatf("f%0d_csyn_err", f), fr_csyn_err, 0);
            chk($sformatf("f%0d_field", f),    vid.FIELD,   exp_field);
            if (t_aa[f]) chk($sformatf("f%0d_aa_count", f), fr_aa, HA * VA);
            if (f == 0) begin
                chk("f0_vs_col",    fr_vs_col,   2);
                chk("f0_hsyn_low",  fr_hsyn_low, HSW * VT);
                chk("f0_vsyn_low",  fr_vsyn_low, VSW * HT);
            end
        end

        // Park mid-line at (line 1, col 10), then stall ce.
        for (int t = 0; t < 50; t++) begin
            vid.iRGB = pix_of((mpos + FR - 1) % FR);
            tick();
            mpos = (mpos + 1) % FR;
        end
        chk("pre_hold_hpos", vid.HPOS, 10);
        ce_pix   = 1'b0;
        vid.iRGB = 8'h33;
        hold_err = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (vid.HPOS !== 9'd10 || vid.VPOS !== 9'd1 || vid.HBLK !== 1'b0 ||
                vid.VBLK !== 1'b0 || vid.HSYN !== 1'b1 || vid.VSYN !== 1'b1 ||
                vid.oRGB !== pix_of(48) || vid.SOF !== 1'b0)
                hold_err++;
        end
        chk("hold_err",  hold_err,  0);
        chk("hold_hpos", vid.HPOS,  10);
        chk("hold_orgb", vid.oRGB,  pix_of(48));

        ce_pix   = 1'b1;
        vid.iRGB = 8'hAA;
        repeat (5) tick();
        chk("pre_rst_hpos", vid.HPOS, 15);
        chk("pre_rst_orgb", vid.oRGB, 8'hAA);

        @(posedge clk_sys);
        #3;
        RESET = 1'b1;
        #1;
        chk("async_hpos", vid.HPOS, 0);
        chk("async_vpos", vid.VPOS, 0);
        chk("async_hblk", vid.HBLK, 1);
        chk("async_vblk", vid.VBLK, 1);
        chk("async_hsyn", vid.HSYN, 1);
        chk("async_vsyn", vid.VSYN, 1);
        chk("async_csyn", vid.CSYN, 1);
        chk("async_orgb", vid.oRGB, 0);
        chk("async_sof",  vid.SOF,  0);
        @(negedge clk_sys);
        RESET = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
